// File: rtl/hilo_div_seq_pkg.sv
// hilo_div_seq_pkg: shared definitions for the HI/LO sequential divider.
//   - FSM state encoding (div_state_e)
//   - default operand width, zero word
//   - ready / start level constants used by the controller
package hilo_div_seq_pkg;

  localparam int unsigned DivWidthDefault = 32;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StByZero = 2'b01,
    StRun    = 2'b10,
    StDone   = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-compare-subtract step.
// Ports:
//   i_rem     - partial remainder entering this step
//   i_quot    - quotient/dividend shift register; MSB is the next dividend bit
//   i_divisor - divisor magnitude
//   o_rem     - partial remainder after the step
//   o_quot    - shift register with the new quotient bit appended at the LSB
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  assign w_shift = {i_rem, i_quot[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, i_divisor});
  // When w_ge holds the true difference is below 2^WIDTH, so modulo arithmetic is exact.
  assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;
  assign o_rem   = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign o_quot  = {i_quot[WIDTH-2:0], w_ge};

endmodule

// File: rtl/hilo_div_seq.sv
// hilo_div_seq: multi-cycle restoring divider producing {HI=remainder, LO=quotient}.
// One quotient bit per cycle; WIDTH cycles from accept to ready, 1 cycle for a zero divisor.
// Optional feature: define DIV_SIGNED_EN to honour signed_i (sign-magnitude correction);
// without it signed_i is ignored and every division is unsigned.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   start_i   - division request, held until ready_o
//   annul_i   - cancel in-flight division
//   signed_i  - 1 = signed DIV, 0 = DIVU
//   opdata1_i - dividend
//   opdata2_i - divisor
//   result_o  - {remainder, quotient}, valid while ready_o
//   ready_o   - result valid / HI-LO write enable
//   busy_o    - high in RUN and BYZERO (stall request)
module hilo_div_seq
  import hilo_div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidthDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int unsigned       CntW     = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0]   LastStep = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  ZeroOp   = WIDTH'(ZeroWord);

  div_state_e         r_state;
  logic [CntW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_divisor;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_busy;

  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_quot_nx;
  logic [WIDTH-1:0]   w_rem_fin;
  logic [WIDTH-1:0]   w_quot_fin;
  logic               w_accept;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_rem_nx),
    .o_quot    (w_quot_nx)
  );

  assign w_accept = (start_i == DivStart) && !annul_i;

`ifdef DIV_SIGNED_EN
  logic w_neg1;
  logic w_neg2;
  logic r_neg_q;
  logic r_neg_r;

  assign w_neg1 = signed_i & opdata1_i[WIDTH-1];
  assign w_neg2 = signed_i & opdata2_i[WIDTH-1];
  assign w_mag1 = w_neg1 ? (ZeroOp - opdata1_i) : opdata1_i;
  assign w_mag2 = w_neg2 ? (ZeroOp - opdata2_i) : opdata2_i;

  // Quotient negative when signs differ; remainder follows the dividend's sign.
  assign w_quot_fin = r_neg_q ? (ZeroOp - w_quot_nx) : w_quot_nx;
  assign w_rem_fin  = r_neg_r ? (ZeroOp - w_rem_nx) : w_rem_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == StIdle && w_accept) begin
      r_neg_q <= w_neg1 ^ w_neg2;
      r_neg_r <= w_neg1;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = signed_i;
  assign w_mag1          = opdata1_i;
  assign w_mag2          = opdata2_i;
  assign w_quot_fin      = w_quot_nx;
  assign w_rem_fin       = w_rem_nx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_ready   <= DivResultNotReady;
      r_busy    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_ready  <= DivResultNotReady;
          r_result <= '0;
          if (w_accept) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= w_mag1;
            r_divisor <= w_mag2;
            r_busy    <= 1'b1;
            r_state   <= (opdata2_i == ZeroOp) ? StByZero : StRun;
          end
        end
        StByZero: begin
          r_busy <= 1'b0;
          if (annul_i) begin
            r_state <= StIdle;
          end else begin
            r_state  <= StDone;
            r_ready  <= DivResultReady;
            r_result <= '0;
          end
        end
        StRun: begin
          if (annul_i) begin
            // Annul wins even on the completing edge.
            r_state  <= StIdle;
            r_busy   <= 1'b0;
            r_result <= '0;
          end else begin
            r_rem  <= w_rem_nx;
            r_quot <= w_quot_nx;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == LastStep) begin
              r_state  <= StDone;
              r_busy   <= 1'b0;
              r_ready  <= DivResultReady;
              r_result <= {w_rem_fin, w_quot_fin};
            end
          end
        end
        StDone: begin
          if (start_i == DivStop) begin
            r_state  <= StIdle;
            r_ready  <= DivResultNotReady;
            r_result <= '0;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;
  assign busy_o   = r_busy;

endmodule
